// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the 7-segment scan controller family.
package seg_scan_pkg;

    localparam int unsigned MAX_NDIG  = 8;
    localparam int unsigned FRAME_W   = 4 * MAX_NDIG;
    localparam int unsigned NIB_SEL_W = $clog2(FRAME_W);
    localparam int unsigned DP_SEL_W  = $clog2(MAX_NDIG);

    localparam logic [3:0] BLANK_NIB = 4'hF;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

    // One display frame, padded to the widest supported digit count.
    typedef struct packed {
        logic                lzs;
        logic [MAX_NDIG-1:0] dp;
        logic [FRAME_W-1:0]  data;
    } frame_t;

    localparam frame_t FRAME_RST = '{lzs: 1'b0, dp: '0, data: '1};

    // Blank every zero digit above digit 0 that has only zeros above it.
    function automatic logic [FRAME_W-1:0] lzs_mask(input logic [FRAME_W-1:0] frame,
                                                    input int unsigned       ndig);
        logic [FRAME_W-1:0] res;
        logic               zrun;
        res  = frame;
        zrun = 1'b1;
        for (int unsigned i = MAX_NDIG - 1; i >= 1; i--) begin
            if (i < ndig) begin
                zrun = zrun && (frame[4*i +: 4] == 4'h0);
                if (zrun) begin
                    res[4*i +: 4] = BLANK_NIB;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Frame-load handshake between a display data source and the scan controller.
interface seg_scan_ctrl_if #(
    parameter int unsigned NDIG = 4
) ();

    logic              LD_VALID;
    logic              LD_READY;
    logic [4*NDIG-1:0] LD_DATA;
    logic [NDIG-1:0]   LD_DP;
    logic              LZS_EN;

    modport master (
        output LD_VALID,
        output LD_DATA,
        output LD_DP,
        output LZS_EN,
        input  LD_READY
    );

    modport slave (
        input  LD_VALID,
        input  LD_DATA,
        input  LD_DP,
        input  LZS_EN,
        output LD_READY
    );

endinterface

// File: rtl/seg_scan_ctrl_tick_gen.sv
// Free-running prescaler: TICK is high for one cycle while the count sits at DIV-1.
module tick_gen #(
    parameter int unsigned DIV = 1000
) (
    input  logic CLK,
    input  logic RST_N,
    output logic TICK
);

    localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q;

    // TICK is registered one count early so it coincides with count = DIV-1.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt_q <= '0;
            TICK  <= 1'b0;
        end else begin
            cnt_q <= (cnt_q == CNT_W'(DIV - 1)) ? '0 : cnt_q + CNT_W'(1);
            TICK  <= (cnt_q == CNT_W'(DIV - 2));
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed N-digit common-anode 7-segment scan controller with
// frame-boundary loading, blanking between digits and leading-zero suppression.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int unsigned NDIG     = 4,
    parameter int unsigned DIV      = 1000,
    parameter int unsigned SHOW_TK  = 16,
    parameter int unsigned BLANK_TK = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    seg_scan_ctrl_if.slave   ld,
    output logic [3:0]       NIB,
    output logic             DP_N,
    output logic [NDIG-1:0]  AN_N,
    output logic             FRAME_END
);

    localparam int unsigned IDX_W  = $clog2(NDIG);
    localparam int unsigned TK_MAX = (SHOW_TK > BLANK_TK) ? SHOW_TK : BLANK_TK;
    localparam int unsigned TK_W   = (TK_MAX > 1) ? $clog2(TK_MAX) : 1;

    logic               tick;
    scan_state_e        state_q, state_d;
    logic [TK_W-1:0]    tk_q, tk_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    frame_t             pend_q, pend_d, act_q, act_d;
    logic               pend_vld_q, pend_vld_d;
    logic               ready_q, ready_d;
    logic               xfer_c, frame_end_c;
    logic [FRAME_W-1:0] disp_c;
    logic [3:0]         nib_d;
    logic               dp_n_d;
    logic [NDIG-1:0]    an_n_d;

    tick_gen #(.DIV(DIV)) u_tick (
        .CLK  (CLK),
        .RST_N(RST_N),
        .TICK (tick)
    );

    assign ld.LD_READY = ready_q;

    // Next-state, handshake and output decode.
    always_comb begin
        state_d     = state_q;
        tk_d        = tk_q;
        idx_d       = idx_q;
        frame_end_c = 1'b0;
        pend_d      = pend_q;

        if (tick) begin
            unique case (state_q)
                ST_BLANK: begin
                    if (tk_q == TK_W'(BLANK_TK - 1)) begin
                        state_d = ST_SHOW;
                        tk_d    = '0;
                    end else begin
                        tk_d = tk_q + TK_W'(1);
                    end
                end
                ST_SHOW: begin
                    if (tk_q == TK_W'(SHOW_TK - 1)) begin
                        state_d = ST_BLANK;
                        tk_d    = '0;
                        if (idx_q == IDX_W'(NDIG - 1)) begin
                            idx_d       = '0;
                            frame_end_c = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        tk_d = tk_q + TK_W'(1);
                    end
                end
                default: state_d = ST_BLANK;
            endcase
        end

        // A load landing on the frame boundary stays pending; only older data commits.
        xfer_c = ld.LD_VALID & ready_q;
        if (xfer_c) begin
            pend_d = '{lzs:  ld.LZS_EN,
                       dp:   MAX_NDIG'(ld.LD_DP),
                       data: FRAME_W'(ld.LD_DATA)};
        end
        act_d      = (frame_end_c && pend_vld_q) ? pend_q : act_q;
        pend_vld_d = xfer_c || (pend_vld_q && !frame_end_c);
        ready_d    = !pend_vld_d;

        // Outputs follow the next state so the new digit's nibble is up for the whole blank.
        disp_c = act_d.lzs ? lzs_mask(act_d.data, NDIG) : act_d.data;
        nib_d  = disp_c[NIB_SEL_W'({idx_d, 2'b00}) +: 4];
        dp_n_d = ~act_d.dp[DP_SEL_W'(idx_d)];
        an_n_d = (state_d == ST_SHOW) ? ~(NDIG'(1) << idx_d) : '1;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= ST_BLANK;
            tk_q       <= '0;
            idx_q      <= '0;
            pend_q     <= FRAME_RST;
            act_q      <= FRAME_RST;
            pend_vld_q <= 1'b0;
            ready_q    <= 1'b1;
            NIB        <= BLANK_NIB;
            DP_N       <= 1'b1;
            AN_N       <= '1;
            FRAME_END  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tk_q       <= tk_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            act_q      <= act_d;
            pend_vld_q <= pend_vld_d;
            ready_q    <= ready_d;
            NIB        <= nib_d;
            DP_N       <= dp_n_d;
            AN_N       <= an_n_d;
            FRAME_END  <= frame_end_c;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIV=4, SHOW_TK=2, BLANK_TK=1, NDIG=4.
module tb_seg_scan_ctrl;

    logic       CLK;
    logic       RST_N;
    logic [3:0] NIB;
    logic       DP_N;
    logic [3:0] AN_N;
    logic       FRAME_END;

    int total = 0;
    int bad   = 0;

    seg_scan_ctrl_if #(.NDIG(4)) ld_if ();

    seg_scan_ctrl #(
        .NDIG    (4),
        .DIV     (4),
        .SHOW_TK (2),
        .BLANK_TK(1)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .ld       (ld_if),
        .NIB      (NIB),
        .DP_N     (DP_N),
        .AN_N     (AN_N),
        .FRAME_END(FRAME_END)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer one frame while ready; it must be taken on the next edge.
    task automatic load(input logic [15:0] data, input logic [3:0] dp, input logic lzs);
        chk("ready_before_load", ld_if.LD_READY, 1'b1);
        ld_if.LD_DATA  = data;
        ld_if.LD_DP    = dp;
        ld_if.LZS_EN   = lzs;
        ld_if.LD_VALID = 1'b1;
        step();
        ld_if.LD_VALID = 1'b0;
        chk("ready_drop", ld_if.LD_READY, 1'b0);
    endtask

    task automatic wait_fe();
        int n;
        n = 0;
        step();
        while (FRAME_END !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk("frame_end_seen", FRAME_END, 1'b1);
    endtask

    // Called in a FRAME_END cycle; checks one whole 48-cycle frame cycle by cycle.
    task automatic scan_frame(input logic [15:0] nibs, input logic [3:0] dpn, input logic rdy);
        logic [3:0] one;
        logic [3:0] exp_an;
        one = 4'b0001;
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 12; c++) begin
                exp_an = (c < 4) ? 4'hF : ~(one << d);
                chk("an_n", AN_N, exp_an);
                chk("nib", NIB, nibs[4*d +: 4]);
                chk("dp_n", DP_N, dpn[d]);
                chk("frame_end", FRAME_END, (d == 0 && c == 0));
                if (d != 0 || c != 0) chk("ld_ready", ld_if.LD_READY, rdy);
                step();
            end
        end
        chk("frame_end_next", FRAME_END, 1'b1);
    endtask

    initial begin
        int n;
        RST_N          = 1'b0;
        ld_if.LD_VALID = 1'b0;
        ld_if.LD_DATA  = 16'h0;
        ld_if.LD_DP    = 4'h0;
        ld_if.LZS_EN   = 1'b0;
        step();
        step();

        chk("rst_an_n", AN_N, 4'hF);
        chk("rst_nib", NIB, 4'hF);
        chk("rst_dp_n", DP_N, 1'b1);
        chk("rst_ready", ld_if.LD_READY, 1'b1);
        chk("rst_frame_end", FRAME_END, 1'b0);
        RST_N = 1'b1;

        // Basic scan order and timing.
        load(16'h1234, 4'h0, 1'b0);
        wait_fe();
        scan_frame(16'h1234, 4'hF, 1'b1);

        // Data without valid is ignored.
        ld_if.LD_DATA = 16'h9999;
        scan_frame(16'h1234, 4'hF, 1'b1);

        // Leading-zero suppression.
        load(16'h0050, 4'h0, 1'b1);
        wait_fe();
        scan_frame(16'hFF50, 4'hF, 1'b1);
        load(16'h0000, 4'h0, 1'b1);
        wait_fe();
        scan_frame(16'hFFF0, 4'hF, 1'b1);
        load(16'h0050, 4'h0, 1'b0);
        wait_fe();
        scan_frame(16'h0050, 4'hF, 1'b1);

        // Second offer while pending is refused.
        load(16'h5678, 4'h0, 1'b0);
        ld_if.LD_DATA  = 16'h8765;
        ld_if.LD_VALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("b_held", ld_if.LD_READY, 1'b0);
        end
        ld_if.LD_VALID = 1'b0;
        wait_fe();
        chk("a_shows", NIB, 4'h8);
        scan_frame(16'h5678, 4'hF, 1'b1);

        // Load accepted on the frame-boundary edge stays pending for a frame.
        for (int i = 0; i < 47; i++) step();
        ld_if.LD_DATA  = 16'h8765;
        ld_if.LD_VALID = 1'b1;
        step();
        ld_if.LD_VALID = 1'b0;
        chk("coinc_fe", FRAME_END, 1'b1);
        chk("coinc_pending", ld_if.LD_READY, 1'b0);
        chk("coinc_old_frame", NIB, 4'h8);
        wait_fe();
        scan_frame(16'h8765, 4'hF, 1'b1);

        // Decimal point follows the digit through blank and show.
        load(16'h3141, 4'b0100, 1'b0);
        wait_fe();
        scan_frame(16'h3141, 4'b1011, 1'b1);

        // Reset in the middle of digit 0's show period.
        for (int i = 0; i < 6; i++) step();
        chk("pre_rst_show", AN_N, 4'b1110);
        RST_N = 1'b0;
        step();
        chk("mid_rst_an_n", AN_N, 4'hF);
        chk("mid_rst_nib", NIB, 4'hF);
        chk("mid_rst_dp_n", DP_N, 1'b1);
        chk("mid_rst_ready", ld_if.LD_READY, 1'b1);
        chk("mid_rst_frame_end", FRAME_END, 1'b0);
        RST_N = 1'b1;
        n = 0;
        while (AN_N === 4'hF && n < 100) begin
            step();
            n++;
        end
        chk("idx_restart", AN_N, 4'b1110);
        chk("frame_cleared", NIB, 4'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
